// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
// Functions are sized for the largest supported requester count (16).
package reg_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First set request bit scanning ptr, ptr+1, ... wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int                 n);
    pick_t res;
    int    j;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (req[j] && !res.found) begin
          res.found = 1'b1;
          res.idx   = MAX_IDW'(j);
        end
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDW-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
// Optional ARB_LOCK_EN adds a per-requester lock input.
interface reg_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [IDW-1:0]         owner;
  logic                   busy;

  modport master (
    output req, wdata,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt, ack, q, q_valid, owner, busy
  );

  modport slave (
    input  req, wdata,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt, ack, q, q_valid, owner, busy
  );
endinterface

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational rotate-priority encoder: picks the first request at or after ptr.
module rr_priority_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   idx
);
  logic [MAX_REQ-1:0] req_ext;
  pick_t              res;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    res                  = rr_pick(req_ext, MAX_IDW'(ptr), N_REQ);
    found                = res.found;
    idx                  = IDW'(res.idx);
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ writers.
// Build with ARB_LOCK_EN to hold the round-robin pointer while lock[winner] is set.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  reg_write_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             hold_ptr;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  assign hold_ptr = bus.lock[winner_q];
`else
  assign hold_ptr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d = pick_idx;
          gnt_d    = N_REQ'(onehot(MAX_IDW'(pick_idx)));
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A requester that lets go before WRITE forfeits without moving ptr.
        if (bus.req[winner_q]) begin
          state_d = WRITE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      WRITE: begin
        q_d       = bus.wdata[winner_q*WIDTH +: WIDTH];
        owner_d   = winner_q;
        q_valid_d = 1'b1;
        ack_d     = N_REQ'(onehot(MAX_IDW'(winner_q)));
        gnt_d     = '0;
        if (!hold_ptr)
          ptr_d = (int'(winner_q) == N_REQ - 1) ? '0 : winner_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == GRANT) || (state_q == WRITE);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; expected commits are queued and matched on each ack.
module tb_reg_write_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } commit_t;

  logic    clk = 1'b0;
  logic    reset;
  int      checks = 0;
  int      errors = 0;
  commit_t exp_q[$];

  reg_write_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  reg_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx);
    commit_t c;
    c.idx  = idx;
    c.data = bus.wdata[idx*WIDTH +: WIDTH];
    exp_q.push_back(c);
  endtask

  // Scoreboard: every ack must match the oldest queued commit.
  always @(negedge clk) begin
    if (!reset && |bus.ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'h0);
      end else begin
        commit_t c;
        c = exp_q.pop_front();
        check("ack_onehot", 32'(bus.ack), 32'(1) << c.idx);
        check("ack_q",      32'(bus.q), 32'(c.data));
        check("ack_owner",  32'(bus.owner), 32'(c.idx));
        check("ack_qvalid", 32'(bus.q_valid), 32'h1);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = {8'hD3, 8'hA5, 8'h81, 8'h50};
`ifdef ARB_LOCK_EN
    bus.lock  = '0;
`endif

    // Reset holds everything cleared even with all requests high.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_gnt",    32'(bus.gnt), 32'h0);
      check("rst_ack",    32'(bus.ack), 32'h0);
      check("rst_q",      32'(bus.q), 32'h0);
      check("rst_qvalid", 32'(bus.q_valid), 32'h0);
      check("rst_owner",  32'(bus.owner), 32'h0);
      check("rst_busy",   32'(bus.busy), 32'h0);
    end

    // Single write from requester 2.
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick(1);
    check("single_gnt_e1", 32'(bus.gnt), 32'h4);
    check("single_busy",   32'(bus.busy), 32'h1);
    check("single_q_pre",  32'(bus.q), 32'h0);
    push(2);
    tick(1);
    check("single_gnt_e2", 32'(bus.gnt), 32'h4);
    tick(1);
    bus.req = 4'b0000;
    check("single_q",      32'(bus.q), 32'hA5);
    check("single_owner",  32'(bus.owner), 32'h2);
    check("single_ack",    32'(bus.ack), 32'h4);
    check("single_gnt_e3", 32'(bus.gnt), 32'h0);
    check("single_qvalid", 32'(bus.q_valid), 32'h1);
    tick(1);
    check("single_ack_gone", 32'(bus.ack), 32'h0);

    // ptr is now 3: requester 3 wins before 0, then ptr wraps.
    bus.req = 4'b1001;
    push(3);
    push(0);
    tick(6);
    bus.req = 4'b0000;
    tick(2);
    check("wrap_owner", 32'(bus.owner), 32'h0);

    // From ptr=0 with everyone requesting: 0,1,2,3,0.
    reset = 1'b1;
    tick(2);
    reset   = 1'b0;
    bus.req = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    tick(15);
    bus.req = 4'b0000;
    tick(4);
    check("rr_drained", 32'(exp_q.size()), 32'h0);
    check("rr_idle",    32'(bus.busy), 32'h0);

    // Requester 1 drops during GRANT: no write, ptr stays at 1.
    bus.req = 4'b0010;
    tick(1);
    check("abort_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick(1);
    check("abort_gnt_clr", 32'(bus.gnt), 32'h0);
    check("abort_busy",    32'(bus.busy), 32'h0);
    check("abort_q",       32'(bus.q), 32'h50);
    check("abort_owner",   32'(bus.owner), 32'h0);
    tick(2);
    bus.req = 4'b0011;
    push(1);
    tick(3);
    bus.req = 4'b0000;
    tick(2);
    check("abort_ptr_kept", 32'(bus.owner), 32'h1);

    // Reset during WRITE aborts with no commit.
    bus.req = 4'b0100;
    tick(2);
    reset = 1'b1;
    tick(1);
    bus.req = 4'b0000;
    check("midrst_ack",    32'(bus.ack), 32'h0);
    check("midrst_q",      32'(bus.q), 32'h0);
    check("midrst_qvalid", 32'(bus.q_valid), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(4);
    check("midrst_idle", 32'(bus.busy), 32'h0);

`ifdef ARB_LOCK_EN
    // Lock keeps requester 0 on top until lock drops.
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    push(0); push(0); push(1);
    tick(5);
    bus.lock = 4'b0000;
    tick(4);
    bus.req = 4'b0000;
    tick(2);
    check("lock_last_owner", 32'(bus.owner), 32'h1);
`endif

    tick(2);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
